// File: rtl/matmul_address_generator_pkg.sv
// rtl/matmul_address_generator_pkg.sv - shared types and width helpers for the matmul address engine
package matmul_address_generator_pkg;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_ACCUM = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int LANES = 4;

   // Index width for a counter spanning 0..n-1, never narrower than one bit.
   function automatic int idx_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic bit is_pow2(input int n);
      return (n > 0) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/matmul_address_generator.sv
// rtl/matmul_address_generator.sv - 4-lane matrix-vector multiply sequencer and address engine
module matmul_address_generator
   import matmul_address_generator_pkg::*;
#(
   parameter int N                         = 16,
   parameter int W_BUFFER_ADDRESS_BITS     = 8,
   parameter int INPUT_BUFFER_ADDRESS_BITS = 4
) (
   input  logic                                 clk,
   input  logic                                 iRST_N,
   output logic [W_BUFFER_ADDRESS_BITS-1:0]     w_in_1_address,
   output logic [W_BUFFER_ADDRESS_BITS-1:0]     w_in_2_address,
   output logic [W_BUFFER_ADDRESS_BITS-1:0]     w_in_3_address,
   output logic [W_BUFFER_ADDRESS_BITS-1:0]     w_in_4_address,
   output logic [INPUT_BUFFER_ADDRESS_BITS-1:0] x_in_1_address,
   output logic [INPUT_BUFFER_ADDRESS_BITS-1:0] x_in_2_address,
   output logic [INPUT_BUFFER_ADDRESS_BITS-1:0] x_in_3_address,
   output logic [INPUT_BUFFER_ADDRESS_BITS-1:0] x_in_4_address,
   output logic [INPUT_BUFFER_ADDRESS_BITS-1:0] out_1_address,
   output logic [INPUT_BUFFER_ADDRESS_BITS-1:0] out_2_address,
   output logic [INPUT_BUFFER_ADDRESS_BITS-1:0] out_3_address,
   output logic [INPUT_BUFFER_ADDRESS_BITS-1:0] out_4_address,
   output logic                                 clear,
   output logic                                 valid,
   output logic                                 write
);

   localparam int WB     = W_BUFFER_ADDRESS_BITS;
   localparam int IB     = INPUT_BUFFER_ADDRESS_BITS;
   localparam int JB     = idx_bits(N);
   localparam int GROUPS = N / LANES;
   localparam int GB     = idx_bits(GROUPS);

   state_t          state, state_nxt;
   logic [GB-1:0]   g, g_nxt;
   logic [JB-1:0]   j, j_nxt;

   logic            clear_nxt, valid_nxt, write_nxt;
   logic [JB-1:0]   row_nxt [LANES];
   logic [WB-1:0]   w_nxt   [LANES];
   logic [WB-1:0]   w_q     [LANES];
   logic [IB-1:0]   out_q   [LANES];
   logic [IB-1:0]   x_q;

   always_ff @(posedge clk) begin
      if (!iRST_N) begin
         state <= ST_CLEAR;
         g     <= '0;
         j     <= '0;
      end else begin
         state <= state_nxt;
         g     <= g_nxt;
         j     <= j_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      g_nxt     = g;
      j_nxt     = j;
      case (state)
         ST_CLEAR: begin
            state_nxt = ST_ACCUM;
            j_nxt     = '0;
         end
         ST_ACCUM: begin
            if (j == JB'(N - 1)) state_nxt = ST_WRITE;
            else                 j_nxt     = j + 1'b1;
         end
         ST_WRITE: begin
            if (g < GB'(GROUPS - 1)) begin
               state_nxt = ST_CLEAR;
               g_nxt     = g + 1'b1;
               j_nxt     = '0;
            end else begin
               state_nxt = ST_DONE;
            end
         end
         default: state_nxt = ST_DONE;
      endcase
   end

   // Outputs are decoded from the next state and registered, so every port is a flop.
   always_comb begin
      clear_nxt = 1'b0;
      valid_nxt = 1'b0;
      write_nxt = 1'b0;
      case (state_nxt)
         ST_CLEAR: clear_nxt = 1'b1;
         ST_ACCUM: valid_nxt = 1'b1;
         ST_WRITE: write_nxt = 1'b1;
         default:  ;
      endcase
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign row_nxt[k] = JB'({g_nxt, 2'(k)});
      if (is_pow2(N)) begin : g_concat
         assign w_nxt[k] = WB'({row_nxt[k], j_nxt});
      end else begin : g_mult
         assign w_nxt[k] = WB'(int'(row_nxt[k]) * N + int'(j_nxt));
      end
   end

   always_ff @(posedge clk) begin
      if (!iRST_N) begin
         clear <= 1'b1;
         valid <= 1'b0;
         write <= 1'b0;
         x_q   <= '0;
         for (int k = 0; k < LANES; k++) begin
            w_q[k]   <= WB'(k * N);
            out_q[k] <= IB'(k);
         end
      end else begin
         clear <= clear_nxt;
         valid <= valid_nxt;
         write <= write_nxt;
         x_q   <= IB'(j_nxt);
         for (int k = 0; k < LANES; k++) begin
            w_q[k]   <= w_nxt[k];
            out_q[k] <= IB'(row_nxt[k]);
         end
      end
   end

   assign w_in_1_address = w_q[0];
   assign w_in_2_address = w_q[1];
   assign w_in_3_address = w_q[2];
   assign w_in_4_address = w_q[3];
   assign x_in_1_address = x_q;
   assign x_in_2_address = x_q;
   assign x_in_3_address = x_q;
   assign x_in_4_address = x_q;
   assign out_1_address  = out_q[0];
   assign out_2_address  = out_q[1];
   assign out_3_address  = out_q[2];
   assign out_4_address  = out_q[3];

endmodule

// File: tb/tb_matmul_address_generator.sv
// tb/tb_matmul_address_generator.sv - directed bench for the matmul address engine (N=16 and N=8)
module tb_matmul_address_generator;

   logic       clk = 1'b0;
   logic       iRST_N = 1'b0;

   logic [7:0] w16 [4];
   logic [3:0] x16 [4];
   logic [3:0] o16 [4];
   logic       c16, v16, wr16;

   logic [5:0] w8 [4];
   logic [2:0] x8 [4];
   logic [2:0] o8 [4];
   logic       c8, v8, wr8;

   int n_pass = 0;
   int n_chk  = 0;

   int acc [4];
   int out_mem [16];
   int seen [256];
   int overlap, nwr, nval, nwr8, maxw8, strobes_idle, wr_abandoned;

   always #5 clk = ~clk;

   matmul_address_generator dut16 (
      .clk            (clk),
      .iRST_N         (iRST_N),
      .w_in_1_address (w16[0]),
      .w_in_2_address (w16[1]),
      .w_in_3_address (w16[2]),
      .w_in_4_address (w16[3]),
      .x_in_1_address (x16[0]),
      .x_in_2_address (x16[1]),
      .x_in_3_address (x16[2]),
      .x_in_4_address (x16[3]),
      .out_1_address  (o16[0]),
      .out_2_address  (o16[1]),
      .out_3_address  (o16[2]),
      .out_4_address  (o16[3]),
      .clear          (c16),
      .valid          (v16),
      .write          (wr16)
   );

   matmul_address_generator #(
      .N                         (8),
      .W_BUFFER_ADDRESS_BITS     (6),
      .INPUT_BUFFER_ADDRESS_BITS (3)
   ) dut8 (
      .clk            (clk),
      .iRST_N         (iRST_N),
      .w_in_1_address (w8[0]),
      .w_in_2_address (w8[1]),
      .w_in_3_address (w8[2]),
      .w_in_4_address (w8[3]),
      .x_in_1_address (x8[0]),
      .x_in_2_address (x8[1]),
      .x_in_3_address (x8[2]),
      .x_in_4_address (x8[3]),
      .out_1_address  (o8[0]),
      .out_2_address  (o8[1]),
      .out_3_address  (o8[2]),
      .out_4_address  (o8[3]),
      .clear          (c8),
      .valid          (v8),
      .write          (wr8)
   );

   // Expected schedule from the cycle index alone: period n+2 = CLEAR, n x ACCUM, WRITE.
   function automatic bit is_done(input int n, input int c);
      return c >= (n / 4) * (n + 2);
   endfunction

   function automatic int exp_strobe(input int n, input int c);
      int ph;
      if (is_done(n, c)) return 0;
      ph = c % (n + 2);
      if (ph == 0) return 4;
      if (ph <= n) return 2;
      return 1;
   endfunction

   function automatic int exp_j(input int n, input int c);
      int ph;
      if (is_done(n, c)) return n - 1;
      ph = c % (n + 2);
      if (ph == 0) return 0;
      if (ph <= n) return ph - 1;
      return n - 1;
   endfunction

   function automatic int exp_row(input int n, input int c, input int k);
      int g;
      g = is_done(n, c) ? (n / 4 - 1) : (c / (n + 2));
      return 4 * g + k;
   endfunction

   function automatic int exp_w(input int n, input int c, input int k);
      return exp_row(n, c, k) * n + exp_j(n, c);
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic int strobes16;
      return (int'(c16) << 2) | (int'(v16) << 1) | int'(wr16);
   endfunction

   function automatic int strobes8;
      return (int'(c8) << 2) | (int'(v8) << 1) | int'(wr8);
   endfunction

   // Entered with cycle 0 (CLEAR of group 0) already sampled.
   task automatic run_pass(input string pname);
      int gold, bad;
      overlap = 0; nwr = 0; nval = 0; nwr8 = 0; maxw8 = 0;
      for (int i = 0; i < 256; i++) seen[i] = 0;
      for (int i = 0; i < 16; i++) out_mem[i] = -99999;
      for (int k = 0; k < 4; k++) acc[k] = 0;
      for (int c = 0; c < 80; c++) begin
         if (c > 0) tick();
         check($sformatf("%s strobe16 c%0d", pname, c), strobes16(), exp_strobe(16, c));
         check($sformatf("%s w1_16 c%0d", pname, c), int'(w16[0]), exp_w(16, c, 0));
         check($sformatf("%s w4_16 c%0d", pname, c), int'(w16[3]), exp_w(16, c, 3));
         check($sformatf("%s x_16 c%0d", pname, c), int'(x16[2]), exp_j(16, c));
         check($sformatf("%s out4_16 c%0d", pname, c), int'(o16[3]), exp_row(16, c, 3));
         check($sformatf("%s strobe8 c%0d", pname, c), strobes8(), exp_strobe(8, c));
         check($sformatf("%s w4_8 c%0d", pname, c), int'(w8[3]), exp_w(8, c, 3));

         if (int'(c16) + int'(v16) + int'(wr16) > 1) overlap++;
         if (c16) for (int k = 0; k < 4; k++) acc[k] = 0;
         if (v16) begin
            nval++;
            for (int k = 0; k < 4; k++) begin
               seen[w16[k]]++;
               acc[k] += (int'(w16[k]) - 128) * (int'(x16[k]) - 8);
            end
         end
         if (wr16) begin
            nwr++;
            for (int k = 0; k < 4; k++) out_mem[o16[k]] = acc[k];
         end
         if (wr8) nwr8++;
         if (v8 && int'(w8[3]) > maxw8) maxw8 = int'(w8[3]);
      end

      check({pname, " overlap"}, overlap, 0);
      check({pname, " writes16"}, nwr, 4);
      check({pname, " valids16"}, nval, 64);
      bad = 0;
      for (int i = 0; i < 256; i++) if (seen[i] != 1) bad++;
      check({pname, " w_coverage"}, bad, 0);
      check({pname, " out0"}, out_mem[0], 1304);
      for (int r = 0; r < 16; r++) begin
         gold = 0;
         for (int jj = 0; jj < 16; jj++) gold += (r * 16 + jj - 128) * (jj - 8);
         check($sformatf("%s out%0d", pname, r), out_mem[r], gold);
      end
      check({pname, " writes8"}, nwr8, 2);
      check({pname, " maxw8"}, maxw8, 63);
   endtask

   initial begin
      iRST_N = 1'b0;
      repeat (3) tick();
      check("rst strobe16", strobes16(), 4);
      check("rst w1", int'(w16[0]), 0);
      check("rst w2", int'(w16[1]), 16);
      check("rst w3", int'(w16[2]), 32);
      check("rst w4", int'(w16[3]), 48);
      check("rst x", int'(x16[0]), 0);
      check("rst out1", int'(o16[0]), 0);
      check("rst out4", int'(o16[3]), 3);
      check("rst w4_8", int'(w8[3]), 24);
      iRST_N = 1'b1;

      run_pass("p1");

      strobes_idle = 0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (strobes16() != 0 || strobes8() != 0) strobes_idle++;
      end
      check("idle strobes", strobes_idle, 0);
      check("idle w4", int'(w16[3]), 255);
      check("idle x", int'(x16[3]), 15);
      check("idle out4", int'(o16[3]), 15);

      iRST_N = 1'b0;
      tick();
      iRST_N = 1'b1;
      wr_abandoned = 0;
      for (int c = 1; c <= 26; c++) begin
         tick();
         if (wr16) wr_abandoned++;
      end
      check("mid g1 j7 strobe", strobes16(), 2);
      check("mid g1 j7 w1", int'(w16[0]), 71);
      check("mid g1 j7 x", int'(x16[0]), 7);
      iRST_N = 1'b0;
      tick();
      check("mid rst strobe", strobes16(), 4);
      check("mid rst w1", int'(w16[0]), 0);
      check("mid rst out1", int'(o16[0]), 0);
      check("mid writes before rst", wr_abandoned, 1);
      iRST_N = 1'b1;

      run_pass("p2");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
